// File: rtl/jt053247_pkg.sv
// Shared definitions for the jt053247 object-drawing engine.
//   state_t  : draw sequencer states
//   ZOOM_ONE : hzoom value giving a 1:1 horizontal scale
//   TILE_END : phase value at which a 16-pixel source row is exhausted
package jt053247_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2,
    DRAW   = 2'd3
  } state_t;

  localparam logic [11:0] ZOOM_ONE = 12'h040;
  localparam logic [12:0] TILE_END = 13'h400;

  // Nibble n of a 64-bit 4bpp row sits at bits [4n+3:4n].
  function automatic logic [3:0] row_nibble(input logic [63:0] row, input logic [3:0] idx);
    return row[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/jt053247_zpix.sv
// Horizontal zoom phase accumulator and source-pixel selector.
//   clk, rst_n, cen : clock, sync active-low reset, clock enable
//   load, keep      : start a row; keep=1 continues the previous fraction
//   step            : advance the phase by hzoom (one output pixel)
//   row64, hflip    : latched 16-pixel source row and its flip
//   hzoom           : source step per output pixel (6 fraction bits)
//   pixel           : source pixel selected by the current phase
//   last            : the phase after this step leaves the tile
//   frac            : fractional phase, carried into a kept next tile
module jt053247_zpix
  import jt053247_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        load,
  input  logic        keep,
  input  logic        step,
  input  logic [63:0] row64,
  input  logic        hflip,
  input  logic [11:0] hzoom,
  output logic [3:0]  pixel,
  output logic        last,
  output logic [5:0]  frac
);

  // 4 integer bits, 6 fraction bits, 3 guard bits
  logic [12:0] ph_q, ph_d;
  logic [12:0] ph_sum;
  logic [3:0]  idx;

  always_comb begin
    ph_sum = ph_q + {1'b0, hzoom};
    ph_d   = ph_q;
    if (load)      ph_d = keep ? {7'd0, ph_q[5:0]} : '0;
    else if (step) ph_d = ph_sum;
    idx   = hflip ? ~ph_q[9:6] : ph_q[9:6];
    pixel = row_nibble(row64, idx);
    last  = (ph_sum >= TILE_END);
    frac  = ph_q[5:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   ph_q <= '0;
    else if (cen) ph_q <= ph_d;
  end

endmodule

// File: rtl/jt053247_draw.sv
// Object-drawing engine: accepts one tile-row request from the sprite
// scanner, fetches its 64-bit 4bpp graphics row in two ROM words, then
// writes the zoomed, non-transparent pixels into the line buffer.
//   clk, rst_n, cen       : clock, sync active-low reset, clock enable
//   dr_start / dr_busy    : request pulse / request in progress
//   code, attr, hflip, vflip, hpos, ysub, hzoom, hz_keep : tile row request
//   rom_addr, rom_cs, rom_ok, rom_data : graphics ROM port
//   buf_we, buf_addr, buf_din          : line-buffer write port
module jt053247_draw
  import jt053247_pkg::*;
#(
  parameter int AW    = 10,
  parameter int MAXPX = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dr_start,
  output logic          dr_busy,
  input  logic [15:0]   code,
  input  logic [AW-1:0] attr,
  input  logic          hflip,
  input  logic          vflip,
  input  logic [8:0]    hpos,
  input  logic [3:0]    ysub,
  input  logic [11:0]   hzoom,
  input  logic          hz_keep,
  output logic [20:0]   rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [31:0]   rom_data,
  output logic          buf_we,
  output logic [8:0]    buf_addr,
  output logic [AW+3:0] buf_din
);

  localparam int CW = $clog2(MAXPX + 1);

  state_t        state_q, state_d;
  logic [AW-1:0] attr_q, attr_d;
  logic          hflip_q, hflip_d;
  logic [11:0]   hzoom_q, hzoom_d;
  logic [63:0]   row_q, row_d;
  logic [8:0]    x_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [20:0]   rom_addr_q, rom_addr_d;
  logic          rom_cs_q, rom_cs_d;
  logic          buf_we_q, buf_we_d;
  logic [8:0]    buf_addr_q, buf_addr_d;
  logic [AW+3:0] buf_din_q, buf_din_d;
  logic          busy_q, busy_d;

  logic       accept;
  logic [3:0] pixel;
  logic       last;
  logic [5:0] frac;

  assign accept = (state_q == IDLE) && dr_start;

  jt053247_zpix u_zpix (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .load  (accept),
    .keep  (hz_keep),
    .step  (state_q == DRAW),
    .row64 (row_q),
    .hflip (hflip_q),
    .hzoom (hzoom_q),
    .pixel (pixel),
    .last  (last),
    .frac  (frac)
  );

  always_comb begin
    state_d    = state_q;
    attr_d     = attr_q;
    hflip_d    = hflip_q;
    hzoom_d    = hzoom_q;
    row_d      = row_q;
    x_d        = x_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    rom_cs_d   = rom_cs_q;
    buf_we_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    buf_din_d  = buf_din_q;
    unique case (state_q)
      IDLE: begin
        if (dr_start) begin
          attr_d     = attr;
          hflip_d    = hflip;
          hzoom_d    = hzoom;
          // x_q still holds where the previous row stopped
          x_d        = hz_keep ? x_q : hpos;
          cnt_d      = '0;
          rom_addr_d = {code, ysub ^ {4{vflip}}, 1'b0};
          rom_cs_d   = 1'b1;
          state_d    = FETCH0;
        end
      end
      FETCH0: begin
        if (rom_ok) begin
          row_d[31:0]   = rom_data;
          rom_addr_d[0] = 1'b1;
          state_d       = FETCH1;
        end
      end
      FETCH1: begin
        if (rom_ok) begin
          row_d[63:32] = rom_data;
          rom_cs_d     = 1'b0;
          state_d      = DRAW;
        end
      end
      DRAW: begin
        buf_we_d   = (pixel != 4'd0);
        buf_addr_d = x_q;
        buf_din_d  = {attr_q, pixel};
        x_d        = x_q + 9'd1;
        cnt_d      = cnt_q + 1'b1;
        if (last || (cnt_q == CW'(MAXPX - 1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      attr_q     <= '0;
      hflip_q    <= 1'b0;
      hzoom_q    <= ZOOM_ONE;
      row_q      <= '0;
      x_q        <= '0;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_din_q  <= '0;
      busy_q     <= 1'b0;
    end else if (cen) begin
      state_q    <= state_d;
      attr_q     <= attr_d;
      hflip_q    <= hflip_d;
      hzoom_q    <= hzoom_d;
      row_q      <= row_d;
      x_q        <= x_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      rom_cs_q   <= rom_cs_d;
      buf_we_q   <= buf_we_d;
      buf_addr_q <= buf_addr_d;
      buf_din_q  <= buf_din_d;
      busy_q     <= busy_d;
    end
  end

  assign dr_busy  = busy_q;
  assign rom_addr = rom_addr_q;
  assign rom_cs   = rom_cs_q;
  assign buf_we   = buf_we_q;
  assign buf_addr = buf_addr_q;
  assign buf_din  = buf_din_q;

endmodule

// File: tb/tb_jt053247_draw.sv
module tb_jt053247_draw;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic          dr_start = 1'b0;
  logic          dr_busy;
  logic [15:0]   code = '0;
  logic [AW-1:0] attr = '0;
  logic          hflip = 1'b0;
  logic          vflip = 1'b0;
  logic [8:0]    hpos = '0;
  logic [3:0]    ysub = '0;
  logic [11:0]   hzoom = '0;
  logic          hz_keep = 1'b0;
  logic [20:0]   rom_addr;
  logic          rom_cs;
  logic          rom_ok = 1'b0;
  logic [31:0]   rom_data = '0;
  logic          buf_we;
  logic [8:0]    buf_addr;
  logic [AW+3:0] buf_din;

  jt053247_draw #(.AW(AW), .MAXPX(256)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dr_start(dr_start), .dr_busy(dr_busy),
    .code(code), .attr(attr), .hflip(hflip), .vflip(vflip), .hpos(hpos),
    .ysub(ysub), .hzoom(hzoom), .hz_keep(hz_keep), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data), .buf_we(buf_we),
    .buf_addr(buf_addr), .buf_din(buf_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]    x;
    logic [AW+3:0] din;
    bit            fin;
  } wr_t;

  wr_t         wq[$];
  logic [20:0] aq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned sx = 0;
  int unsigned sfrac = 0;
  bit          cen_hold = 1'b1;
  bit          stall_f1 = 1'b0;

  // Graphics ROM: code 0x0123 holds a row whose pixel n has value n.
  function automatic logic [31:0] rom_word(input logic [20:0] a);
    if (a[20:5] == 16'h0123) return a[0] ? 32'hFEDCBA98 : 32'h76543210;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!cen_hold) cen = ($urandom_range(0, 3) != 0);

  always @(negedge clk) begin
    rom_data = rom_word(rom_addr);
    rom_ok   = rom_cs && !(stall_f1 && rom_addr[0]) && ($urandom_range(0, 2) != 0);
  end

  // Monitor: ROM word acceptances and line-buffer writes against the queues.
  bit          mon_ed, mon_acc;
  logic [20:0] mon_addr;
  wr_t         mon_e;
  always @(posedge clk) begin
    mon_ed   = cen && rst_n;
    mon_acc  = cen && rst_n && rom_cs && rom_ok;
    mon_addr = rom_addr;
    #1;
    if (mon_acc) begin
      if (aq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rom_unexpected: got addr %0h expected no fetch", mon_addr);
      end else check("rom_addr", 32'(mon_addr), 32'(aq.pop_front()));
    end
    if (mon_ed && buf_we) begin
      if (wq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL wr_unexpected: got write x=%0d din=%0h expected none", buf_addr, buf_din);
      end else begin
        mon_e = wq.pop_front();
        check("buf_addr", 32'(buf_addr), 32'(mon_e.x));
        check("buf_din", 32'(buf_din), 32'(mon_e.din));
        check("busy_at_write", 32'(dr_busy), 32'(!mon_e.fin));
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", 32'(dr_busy), 0);
    check("rst_buf_we", 32'(buf_we), 0);
    check("rst_rom_cs", 32'(rom_cs), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_buf_addr", 32'(buf_addr), 0);
    check("rst_buf_din", 32'(buf_din), 0);
  endtask

  // Reference: walk the source row with the zoom rules and queue the expected writes.
  task automatic issue(input logic [15:0] c, input logic [AW-1:0] a, input bit hf,
                       input bit vf, input logic [8:0] hp, input logic [3:0] ys,
                       input logic [11:0] hz, input bit keep, input bit noise,
                       input int stall, input bit abort);
    logic [20:0] ra;
    logic [63:0] row;
    logic [3:0]  p;
    int unsigned x, ph, n, i, src, k;
    wr_t         e;
    ra  = {c, ys ^ {4{vf}}, 1'b0};
    row = {rom_word(ra | 21'd1), rom_word(ra)};
    x   = keep ? sx : 32'(hp);
    ph  = keep ? sfrac : 0;
    n   = 0;
    do begin
      i   = ph / 64;
      src = hf ? 15 - i : i;
      p   = row[src*4 +: 4];
      ph  = ph + hz;
      n++;
      if (p != 4'd0) begin
        e.x   = x[8:0];
        e.din = {a, p};
        e.fin = (ph >= 1024) || (n == 256);
        wq.push_back(e);
      end
      x = (x + 1) % 512;
    end while (ph < 1024 && n < 256);
    sx    = x;
    sfrac = ph % 64;
    aq.push_back(ra);
    aq.push_back(ra | 21'd1);

    if (stall > 0) stall_f1 = 1'b1;
    @(negedge clk);
    code = c; attr = a; hflip = hf; vflip = vf; hpos = hp; ysub = ys;
    hzoom = hz; hz_keep = keep; dr_start = 1'b1;
    @(posedge clk);
    while (!cen) @(posedge clk);
    #1 check("busy_after_accept", 32'(dr_busy), 1);
    @(negedge clk);
    dr_start = 1'b0;
    code = 16'(~c); hpos = 9'($urandom); hzoom = 12'($urandom); hflip = ~hf;

    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clk);
        dr_start = 1'($urandom_range(0, 1));
        code = 16'hBEEF;
      end
      dr_start = 1'b0;
      check("stall_rom_cs", 32'(rom_cs), 1);
      check("stall_busy", 32'(dr_busy), 1);
      check("stall_fetch1", 32'(rom_addr[0]), 1);
      check("stall_no_write", 32'(buf_we), 0);
      stall_f1 = 1'b0;
    end

    if (abort) begin
      repeat (20) @(negedge clk);
      cen_hold = 1'b1; cen = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; cen_hold = 1'b0;
      wq.delete(); aq.delete();
      sx = 0; sfrac = 0;
      check_reset_outputs();
      repeat (10) @(negedge clk);
      return;
    end

    k = 0;
    while (dr_busy && k < 4000) begin
      @(negedge clk);
      dr_start = noise && dr_busy && ($urandom_range(0, 5) == 0);
      if (dr_start) begin
        code = 16'($urandom); hpos = 9'($urandom); hzoom = 12'($urandom);
      end
      k++;
    end
    dr_start = 1'b0;
    check("busy_timeout", 32'(k < 4000), 1);
    check("wr_outstanding", 32'(wq.size()), 0);
    check("rom_outstanding", 32'(aq.size()), 0);
    wq.delete(); aq.delete();
  endtask

  initial begin
    logic [11:0] hz;
    int unsigned r;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1; cen_hold = 1'b0;
    repeat (2) @(negedge clk);

    issue(16'h0123, 10'h155, 0, 0, 9'd100, 4'd5, 12'h040, 0, 0, 0, 0);
    issue(16'h0123, 10'h2AA, 1, 1, 9'd100, 4'd5, 12'h040, 0, 0, 0, 0);
    issue(16'h0123, 10'h011, 0, 0, 9'd100, 4'd5, 12'h080, 0, 0, 0, 0);
    issue(16'h0123, 10'h022, 0, 0, 9'd100, 4'd5, 12'h020, 0, 0, 0, 0);
    issue(16'h0123, 10'h033, 0, 0, 9'd100, 4'd5, 12'h030, 0, 0, 0, 0);
    issue(16'h0123, 10'h044, 0, 0, 9'd116, 4'd5, 12'h030, 1, 0, 0, 0);
    issue(16'h4A5B, 10'h3FF, 0, 0, 9'd200, 4'd3, 12'h000, 0, 0, 0, 0);
    issue(16'h0123, 10'h066, 1, 0, 9'd50,  4'd5, 12'h401, 0, 0, 0, 0);
    issue(16'h0123, 10'h077, 0, 0, 9'd505, 4'd5, 12'h040, 0, 0, 0, 0);
    issue(16'h0123, 10'h088, 0, 0, 9'd10,  4'd5, 12'h040, 0, 1, 50, 0);
    issue(16'h0123, 10'h099, 0, 0, 9'd30,  4'd5, 12'h010, 0, 0, 0, 1);
    issue(16'h0123, 10'h0AA, 0, 0, 9'd300, 4'd5, 12'h040, 1, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      hz = 12'($urandom);
      else if (r == 1) hz = 12'h000;
      else if (r == 2) hz = 12'($urandom_range(1, 16));
      else             hz = 12'($urandom_range(16, 256));
      issue(16'($urandom), AW'($urandom), 1'($urandom), 1'($urandom), 9'($urandom),
            4'($urandom), hz, 1'($urandom), 1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
